// File: rtl/axi_pkg.sv
// Shared AXI write-path definitions: arbiter FSM states, grant index width,
// AXI burst and response codes.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam int GID_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rr_pick.sv
// Round-robin pick: first set request scanning from rr_ptr upward, modulo NREQ.
// Purely combinational, no backpressure of its own.
module axi_rr_pick
    import axi_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] rr_ptr,
    output logic [GID_W-1:0] idx,
    output logic             any
);

    logic [2*NREQ-1:0] rot;
    logic [GID_W:0]    sum;

    // Rotating the doubled vector puts rr_ptr at bit 0; scanning downward lets the lowest hit win.
    always_comb begin
        rot = {req, req} >> rr_ptr;
        idx = '0;
        any = 1'b0;
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                sum = {1'b0, rr_ptr} + (GID_W + 1)'(k);
                if (sum >= (GID_W + 1)'(NREQ)) begin
                    sum = sum - (GID_W + 1)'(NREQ);
                end
                idx = sum[GID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin share of one AXI write port; AW valid one cycle after request, one idle cycle after B.
// Ready/valid pass combinationally to/from the winner only; losers see 0 and hold their requests.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic                   axi_aclk,
    input  logic                   rst,
    input  logic [NREQ*AW-1:0]     req_awaddr,
    input  logic [NREQ*8-1:0]      req_awlen,
    input  logic [NREQ*3-1:0]      req_awsize,
    input  logic [NREQ*2-1:0]      req_awburst,
    input  logic [NREQ-1:0]        req_awvalid,
    output logic [NREQ-1:0]        req_awready,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    input  logic [NREQ-1:0]        req_wlast,
    input  logic [NREQ-1:0]        req_wvalid,
    output logic [NREQ-1:0]        req_wready,
    output logic [1:0]             req_bresp,
    output logic [NREQ-1:0]        req_bvalid,
    input  logic [NREQ-1:0]        req_bready,
    output logic [AW-1:0]          axi_awaddr,
    output logic [7:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [DW-1:0]          axi_wdata,
    output logic [DW/8-1:0]        axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    input  logic [1:0]             axi_bresp,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   err_wlast
);

    localparam int SW = DW / 8;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_state_t        state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [7:0]       beat_q, beat_d;

    logic [IW-1:0]    gidx;
    logic [NREQ-1:0]  win_mask;
    logic [GID_W-1:0] pick_idx;
    logic             pick_any;

    axi_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_awvalid),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign gidx     = grant_q[IW-1:0];
    assign win_mask = {{(NREQ-1){1'b0}}, 1'b1} << gidx;

    // Payload always follows the registered winner; only the valids are gated by state.
    assign axi_awaddr  = req_awaddr[gidx*AW +: AW];
    assign axi_awlen   = req_awlen[gidx*8 +: 8];
    assign axi_awsize  = req_awsize[gidx*3 +: 3];
    assign axi_awburst = req_awburst[gidx*2 +: 2];
    assign axi_wdata   = req_wdata[gidx*DW +: DW];
    assign axi_wstrb   = req_wstrb[gidx*SW +: SW];
    assign req_bresp   = axi_bresp;

    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign err_wlast = err_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        err_d       = err_q;
        beat_d      = beat_q;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        req_awready = '0;
        req_wready  = '0;
        req_bvalid  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Grant is held even if the winner withdraws; awvalid simply follows it.
                axi_awvalid = req_awvalid[gidx];
                req_awready = win_mask & {NREQ{axi_awready}};
                if (axi_awvalid && axi_awready) begin
                    beat_d  = req_awlen[gidx*8 +: 8];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                axi_wvalid = req_wvalid[gidx];
                axi_wlast  = (beat_q == 8'd0);
                req_wready = win_mask & {NREQ{axi_wready}};
                if (axi_wvalid && axi_wready) begin
                    if (req_wlast[gidx] != axi_wlast) begin
                        err_d = 1'b1;
                    end
                    if (beat_q == 8'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q - 8'd1;
                    end
                end
            end
            ST_RESP: begin
                axi_bready = req_bready[gidx];
                req_bvalid = win_mask & {NREQ{axi_bvalid}};
                if (axi_bvalid && axi_bready) begin
                    rr_ptr_d = (grant_q == GID_W'(NREQ - 1)) ? '0 : grant_q + GID_W'(1);
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: requester and slave behaviour models
// plus a transaction-level round-robin scoreboard.
module tb_axi_wr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;

    logic                 axi_aclk = 1'b0;
    logic                 rst;
    logic [NREQ*AW-1:0]   req_awaddr;
    logic [NREQ*8-1:0]    req_awlen;
    logic [NREQ*3-1:0]    req_awsize;
    logic [NREQ*2-1:0]    req_awburst;
    logic [NREQ-1:0]      req_awvalid;
    logic [NREQ-1:0]      req_awready;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      req_wlast;
    logic [NREQ-1:0]      req_wvalid;
    logic [NREQ-1:0]      req_wready;
    logic [1:0]           req_bresp;
    logic [NREQ-1:0]      req_bvalid;
    logic [NREQ-1:0]      req_bready;
    logic [AW-1:0]        axi_awaddr;
    logic [7:0]           axi_awlen;
    logic [2:0]           axi_awsize;
    logic [1:0]           axi_awburst;
    logic                 axi_awvalid;
    logic                 axi_awready;
    logic [DW-1:0]        axi_wdata;
    logic [SW-1:0]        axi_wstrb;
    logic                 axi_wlast;
    logic                 axi_wvalid;
    logic                 axi_wready;
    logic [1:0]           axi_bresp;
    logic                 axi_bvalid;
    logic                 axi_bready;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 err_wlast;

    always #5 axi_aclk = ~axi_aclk;

    axi_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .axi_aclk    (axi_aclk),
        .rst         (rst),
        .req_awaddr  (req_awaddr),
        .req_awlen   (req_awlen),
        .req_awsize  (req_awsize),
        .req_awburst (req_awburst),
        .req_awvalid (req_awvalid),
        .req_awready (req_awready),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_wlast   (req_wlast),
        .req_wvalid  (req_wvalid),
        .req_wready  (req_wready),
        .req_bresp   (req_bresp),
        .req_bvalid  (req_bvalid),
        .req_bready  (req_bready),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_wlast   (err_wlast)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requester models: phase 0 idle, 1 address, 2 data, 3 response
    int          m_ph[NREQ];
    int          m_len[NREQ];
    int          m_beat[NREQ];
    int          m_left[NREQ];
    logic [AW-1:0] m_addr[NREQ];
    logic        m_wv[NREQ];
    logic        m_br[NREQ];
    logic        h_aw[NREQ];
    logic        h_w[NREQ];
    logic        h_b[NREQ];

    // Slave model
    logic        s_bv;
    logic [1:0]  s_resp;
    int          s_stall;
    logic        s_aw_hs, s_wl_hs, s_b_hs;

    // Stimulus knobs
    int          k_req_pct, k_len, k_awr_pct, k_wr_pct, k_wv_pct, k_wstall;
    logic        k_bad;

    // Scoreboard
    logic        mdl_act, mdl_first, mdl_aw_done, mdl_wdone, mdl_err;
    int          mdl_win, mdl_rr, mdl_len, mdl_wcnt;
    int          grant_log[$];

    function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a, input int b);
        return {a, a ^ (32'(b) * 32'h9E3779B9)};
    endfunction

    function automatic logic [SW-1:0] spat(input logic [AW-1:0] a, input int b);
        return SW'(a[7:0] ^ 8'(b * 37));
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_awaddr[i*AW +: AW]  = m_addr[i];
            req_awlen[i*8 +: 8]     = 8'(m_len[i]);
            req_awsize[i*3 +: 3]    = 3'd3;
            req_awburst[i*2 +: 2]   = 2'b01;
            req_awvalid[i]          = (m_ph[i] == 1);
            req_wdata[i*DW +: DW]   = wpat(m_addr[i], m_beat[i]);
            req_wstrb[i*SW +: SW]   = spat(m_addr[i], m_beat[i]);
            req_wlast[i]            = (m_beat[i] == m_len[i]) || (k_bad && i == 0 && m_beat[i] == 1);
            req_wvalid[i]           = m_wv[i];
            req_bready[i]           = m_br[i];
        end
        axi_bvalid = s_bv;
        axi_bresp  = s_resp;
    endtask

    task automatic tb_clear();
        for (int i = 0; i < NREQ; i++) begin
            m_ph[i] = 0; m_len[i] = 0; m_beat[i] = 0; m_left[i] = 0;
            m_addr[i] = '0; m_wv[i] = 1'b0; m_br[i] = 1'b0;
            h_aw[i] = 1'b0; h_w[i] = 1'b0; h_b[i] = 1'b0;
        end
        s_bv = 1'b0; s_resp = 2'b00; s_stall = 0;
        s_aw_hs = 1'b0; s_wl_hs = 1'b0; s_b_hs = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0;
        mdl_act = 1'b0; mdl_first = 1'b0; mdl_aw_done = 1'b0; mdl_wdone = 1'b0;
        mdl_err = 1'b0; mdl_win = 0; mdl_rr = 0; mdl_len = 0; mdl_wcnt = 0;
        drive();
    endtask

    task automatic setup(input int n0, input int n1, input int req_pct, input int len,
                         input int awr, input int wr, input int wv, input int wstall, input logic bad);
        m_left[0] = n0; m_left[1] = n1;
        k_req_pct = req_pct; k_len = len; k_awr_pct = awr; k_wr_pct = wr;
        k_wv_pct = wv; k_wstall = wstall; k_bad = bad;
        grant_log.delete();
    endtask

    task automatic sample();
        for (int i = 0; i < NREQ; i++) begin
            h_aw[i] = req_awvalid[i] & req_awready[i];
            h_w[i]  = req_wvalid[i] & req_wready[i];
            h_b[i]  = req_bvalid[i] & req_bready[i];
        end
        s_aw_hs = axi_awvalid & axi_awready;
        s_wl_hs = axi_wvalid & axi_wready & axi_wlast;
        s_b_hs  = axi_bvalid & axi_bready;
    endtask

    task automatic monitor();
        logic [NREQ-1:0] wm;
        logic aw_hs, w_hs, b_hs, exp_last;
        aw_hs = axi_awvalid & axi_awready;
        w_hs  = axi_wvalid & axi_wready;
        b_hs  = axi_bvalid & axi_bready;
        chk("err_wlast", err_wlast, mdl_err);
        if (!mdl_act) begin
            chk("idle_busy", busy, 0);
            chk("idle_outs", {axi_awvalid, axi_wvalid, axi_bready, req_awready, req_wready, req_bvalid}, 0);
            if (|req_awvalid) begin
                mdl_win = rr_pick(req_awvalid, mdl_rr);
                grant_log.push_back(mdl_win);
                mdl_act = 1'b1; mdl_first = 1'b1; mdl_aw_done = 1'b0;
                mdl_wdone = 1'b0; mdl_wcnt = 0;
            end
        end else begin
            wm = '0;
            wm[mdl_win] = 1'b1;
            chk("grant_id", grant_id, mdl_win);
            chk("busy", busy, 1);
            if (mdl_first) chk("aw_latency", axi_awvalid, 1);
            mdl_first = 1'b0;
            chk("loser_rdy", {req_awready & ~wm, req_wready & ~wm, req_bvalid & ~wm}, 0);
            if (!mdl_aw_done) chk("w_before_aw", {req_wready, axi_wvalid}, 0);
            if (aw_hs) begin
                chk("aw_twice", mdl_aw_done, 0);
                chk("awaddr", axi_awaddr, m_addr[mdl_win]);
                chk("awlen", axi_awlen, m_len[mdl_win]);
                chk("awsize_burst", {axi_awsize, axi_awburst}, 5'b011_01);
                chk("awready_route", req_awready, wm);
                mdl_aw_done = 1'b1;
                mdl_len = m_len[mdl_win];
            end
            if (w_hs) begin
                if (!mdl_aw_done || mdl_wdone) begin
                    chk("extra_w", w_hs, 0);
                end else begin
                    exp_last = (mdl_wcnt == mdl_len);
                    chk("wdata", axi_wdata, wpat(m_addr[mdl_win], mdl_wcnt));
                    chk("wstrb", axi_wstrb, spat(m_addr[mdl_win], mdl_wcnt));
                    chk("wlast", axi_wlast, exp_last);
                    chk("wready_route", req_wready, wm);
                    if (req_wlast[mdl_win] != exp_last) mdl_err = 1'b1;
                    mdl_wcnt++;
                    if (exp_last) mdl_wdone = 1'b1;
                end
            end
            if (b_hs) begin
                chk("b_after_w", mdl_wdone, 1);
                chk("bvalid_route", req_bvalid, wm);
                chk("bresp", req_bresp, s_resp);
                mdl_rr  = (mdl_win + 1) % NREQ;
                mdl_act = 1'b0;
            end
        end
    endtask

    task automatic update();
        for (int i = 0; i < NREQ; i++) begin
            case (m_ph[i])
                0: if (m_left[i] > 0 && $urandom_range(99) < k_req_pct) begin
                       m_ph[i]   = 1;
                       m_addr[i] = $urandom;
                       m_len[i]  = (k_len < 0) ? int'($urandom_range(7)) : k_len;
                       m_beat[i] = 0;
                       m_wv[i]   = ($urandom_range(99) < k_wv_pct);
                   end
                1: begin
                       if (h_aw[i]) m_ph[i] = 2;
                       if (!m_wv[i]) m_wv[i] = ($urandom_range(99) < k_wv_pct);
                   end
                2: if (h_w[i]) begin
                       m_beat[i]++;
                       if (m_beat[i] > m_len[i]) begin
                           m_ph[i] = 3;
                           m_wv[i] = 1'b0;
                       end else begin
                           m_wv[i] = ($urandom_range(99) < k_wv_pct);
                       end
                   end else if (!m_wv[i]) begin
                       m_wv[i] = ($urandom_range(99) < k_wv_pct);
                   end
                default: if (h_b[i]) begin
                       m_ph[i] = 0;
                       m_br[i] = 1'b0;
                       m_left[i]--;
                   end else begin
                       m_br[i] = ($urandom_range(99) < 70);
                   end
            endcase
        end
        if (s_b_hs) s_bv = 1'b0;
        if (s_wl_hs) begin
            s_bv   = 1'b1;
            s_resp = 2'($urandom_range(3));
        end
        if (s_aw_hs) s_stall = k_wstall;
        axi_awready = ($urandom_range(99) < k_awr_pct);
        if (s_stall > 0) begin
            axi_wready = 1'b0;
            s_stall--;
        end else begin
            axi_wready = ($urandom_range(99) < k_wr_pct);
        end
        drive();
    endtask

    task automatic run(input int max_cyc, input int stop_beats);
        int   cyc;
        logic done;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge axi_aclk);
            sample();
            monitor();
            @(posedge axi_aclk);
            #1;
            update();
            cyc++;
            if (stop_beats > 0 && mdl_act && mdl_wcnt >= stop_beats) return;
            done = !mdl_act;
            for (int i = 0; i < NREQ; i++) begin
                if (m_left[i] != 0 || m_ph[i] != 0) done = 1'b0;
            end
            if (!done && cyc >= max_cyc) begin
                chk("run_done", done, 1);
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        k_bad = 1'b0;
        tb_clear();
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("rst_busy_grant_err", {busy, grant_id, err_wlast}, 0);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready}, 0);
        chk("rst_req_rdy", {req_awready, req_wready, req_bvalid}, 0);
        rst = 1'b0;

        // Both requesters together from rr_ptr=0: req0 then req1
        setup(1, 1, 100, -1, 70, 70, 80, 0, 1'b0);
        run(300, 0);
        chk("simul_count", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("simul_order", {grant_log[0][3:0], grant_log[1][3:0]}, 8'h01);

        // Both keep requesting: grants alternate starting from 0
        setup(3, 3, 100, -1, 80, 80, 80, 0, 1'b0);
        run(600, 0);
        chk("alt_count", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size(); k++) chk("alt_order", grant_log[k], k % 2);

        // Req0 alone, awlen=3, slave always ready
        setup(1, 0, 100, 3, 100, 100, 100, 0, 1'b0);
        run(100, 0);
        chk("single_count", grant_log.size(), 1);

        // awlen=0 with wready held low three cycles
        setup(0, 1, 100, 0, 100, 100, 100, 3, 1'b0);
        run(100, 0);
        chk("len0_count", grant_log.size(), 1);

        // Early wlast on beat 2 of a 4-beat burst
        setup(1, 0, 100, 3, 100, 100, 100, 0, 1'b1);
        run(100, 0);
        chk("err_set", err_wlast, 1);
        k_bad = 1'b0;

        // Random traffic
        setup(15, 15, 40, -1, 60, 60, 70, 0, 1'b0);
        run(4000, 0);
        chk("err_sticky", err_wlast, 1);

        // Leave rr_ptr at 1, then reset during a req1 burst
        setup(1, 0, 100, 1, 100, 100, 100, 0, 1'b0);
        run(100, 0);
        setup(0, 1, 100, 3, 100, 100, 100, 0, 1'b0);
        run(100, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valids", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready}, 0);
        chk("arst_req_rdy", {req_awready, req_wready, req_bvalid}, 0);
        chk("arst_state", {busy, grant_id, err_wlast}, 0);
        tb_clear();
        @(posedge axi_aclk);
        #1;
        rst = 1'b0;
        setup(1, 1, 100, -1, 80, 80, 80, 0, 1'b0);
        run(300, 0);
        chk("post_rst_count", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
